// File: rtl/fbuf_write_arbiter.sv
// Two-requester write arbiter for the framebuffer BRAM port: round-robin with burst
// locking, registered writes, out-of-range suppression and stalled-burst timeout.
module fbuf_write_arbiter #(
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int FBUF_DEPTH      = 307200,
  parameter int LOCK_TIMEOUT    = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [FBUF_ADDR_WIDTH-1:0] req0_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] req0_data,
  input  logic                       req0_last,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [FBUF_ADDR_WIDTH-1:0] req1_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] req1_data,
  input  logic                       req1_last,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  output logic [1:0]                 grant,
  output logic [CNT_WIDTH-1:0]       oob_count,
  output logic [CNT_WIDTH-1:0]       timeout_count
);

  localparam int IW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [FBUF_ADDR_WIDTH:0] LP_DEPTH = (FBUF_ADDR_WIDTH + 1)'(FBUF_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t                     r_state, w_next;
  logic                       r_ptr, w_ptr_next;   // 0 favours requester 0
  logic [IW-1:0]              r_idle_cnt;
  logic                       r_wr;
  logic [FBUF_ADDR_WIDTH-1:0] r_addr;
  logic [FBUF_DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]       r_oob, r_tmo;

  logic                       w_acc0, w_acc1, w_acc, w_last, w_inrange;
  logic                       w_idle, w_tmo, w_release;
  logic [FBUF_ADDR_WIDTH-1:0] w_addr;
  logic [FBUF_DATA_WIDTH-1:0] w_data;

  assign w_acc0    = (r_state == OWN0) && req0_valid;
  assign w_acc1    = (r_state == OWN1) && req1_valid;
  assign w_acc     = w_acc0 || w_acc1;
  assign w_addr    = w_acc1 ? req1_addr : req0_addr;
  assign w_data    = w_acc1 ? req1_data : req0_data;
  assign w_last    = w_acc1 ? req1_last : req0_last;
  assign w_inrange = {1'b0, w_addr} < LP_DEPTH;

  // Timeout fires on the LOCK_TIMEOUT-th consecutive idle cycle of the owner.
  assign w_idle    = ((r_state == OWN0) && !req0_valid) || ((r_state == OWN1) && !req1_valid);
  assign w_tmo     = w_idle && (r_idle_cnt == IW'(LOCK_TIMEOUT - 1));
  assign w_release = (w_acc && w_last) || w_tmo;

  always_comb begin
    w_next     = r_state;
    w_ptr_next = r_ptr;
    case (r_state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !r_ptr)) w_next = OWN0;
        else if (req1_valid)                       w_next = OWN1;
      end
      OWN0: if (w_release) begin
        w_ptr_next = 1'b1;
        w_next     = req1_valid ? OWN1 : IDLE;
      end
      OWN1: if (w_release) begin
        w_ptr_next = 1'b0;
        w_next     = req0_valid ? OWN0 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_idle_cnt <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_oob      <= '0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_next;
      r_ptr      <= w_ptr_next;
      r_idle_cnt <= (w_tmo || !w_idle) ? '0 : r_idle_cnt + 1'b1;
      r_wr       <= w_acc && w_inrange;
      if (w_acc && w_inrange) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
      if (w_acc && !w_inrange && (r_oob != '1)) r_oob <= r_oob + 1'b1;
      if (w_tmo && (r_tmo != '1))               r_tmo <= r_tmo + 1'b1;
    end
  end

  assign req0_ready    = (r_state == OWN0);
  assign req1_ready    = (r_state == OWN1);
  assign grant         = {r_state == OWN1, r_state == OWN0};
  assign fbuf_en_wr    = r_wr;
  assign fbuf_wrea     = r_wr;
  assign fbuf_addr     = r_addr;
  assign fbuf_data     = r_data;
  assign oob_count     = r_oob;
  assign timeout_count = r_tmo;

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Directed bench for fbuf_write_arbiter: grant sequencing, burst lock, OOB,
// lock timeout and asynchronous reset, all against hand-computed values.
module tb_fbuf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid, req0_ready, req0_last;
  logic [18:0] req0_addr;
  logic [7:0]  req0_data;
  logic        req1_valid, req1_ready, req1_last;
  logic [18:0] req1_addr;
  logic [7:0]  req1_data;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;
  logic [1:0]  grant;
  logic [15:0] oob_count, timeout_count;

  int n_vec = 0;
  int n_err = 0;

  fbuf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_last(req1_last),
    .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr),
    .fbuf_data(fbuf_data), .grant(grant), .oob_count(oob_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d0(input logic v, input logic [18:0] a, input logic [7:0] d, input logic l);
    req0_valid = v; req0_addr = a; req0_data = d; req0_last = l;
  endtask

  task automatic d1(input logic v, input logic [18:0] a, input logic [7:0] d, input logic l);
    req1_valid = v; req1_addr = a; req1_data = d; req1_last = l;
  endtask

  // Expect a BRAM write of (a,d) visible now.
  task automatic wr(input string tag, input logic [18:0] a, input logic [7:0] d);
    chk({tag, "_en"}, fbuf_en_wr, 1);
    chk({tag, "_we"}, fbuf_wrea, 1);
    chk({tag, "_addr"}, fbuf_addr, a);
    chk({tag, "_data"}, fbuf_data, d);
  endtask

  task automatic do_reset();
    d0(0, 0, 0, 0); d1(0, 0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    d0(0, 0, 0, 0); d1(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_en", fbuf_en_wr, 0);
    chk("rst_we", fbuf_wrea, 0);
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
    chk("rst_oob", oob_count, 0);
    chk("rst_tmo", timeout_count, 0);
    chk("rst_addr", fbuf_addr, 0);
    tick();
    rst_n = 1'b1;

    // single 3-beat burst from requester 0
    d0(1, 10, 8'hA1, 0);
    tick(); chk("s_grant", grant, 2'b01); chk("s_en0", fbuf_en_wr, 0);
    tick(); wr("s_b1", 10, 8'hA1); d0(1, 11, 8'hA2, 0);
    tick(); wr("s_b2", 11, 8'hA2); d0(1, 12, 8'hA3, 1);
    tick(); wr("s_b3", 12, 8'hA3); chk("s_rel", grant, 0); d0(0, 0, 0, 0);
    tick(); chk("s_idle_en", fbuf_en_wr, 0); chk("s_hold", fbuf_addr, 12);

    // contention from reset: req0 then req1 back-to-back, then req0 again
    do_reset();
    d0(1, 100, 8'h10, 0); d1(1, 200, 8'h20, 0);
    tick(); chk("c_g0", grant, 2'b01); chk("c_rdy1", req1_ready, 0);
    tick(); wr("c_a", 100, 8'h10); d0(1, 101, 8'h11, 1);
    tick(); wr("c_b", 101, 8'h11); chk("c_g1", grant, 2'b10); d0(0, 0, 0, 0);
    tick(); wr("c_c", 200, 8'h20); d1(1, 201, 8'h21, 1);
    tick(); wr("c_d", 201, 8'h21); chk("c_gi", grant, 0);
    d0(1, 110, 8'h30, 1); d1(1, 210, 8'h40, 1);
    tick(); chk("c_r2g0", grant, 2'b01);
    tick(); wr("c_e", 110, 8'h30); chk("c_r2g1", grant, 2'b10); d0(0, 0, 0, 0);
    tick(); wr("c_f", 210, 8'h40); chk("c_r2gi", grant, 0); d1(0, 0, 0, 0);

    // burst lock: req1 arrives mid 4-beat req0 burst
    d0(1, 300, 8'h50, 0);
    tick(); chk("l_g0", grant, 2'b01);
    tick(); wr("l_a", 300, 8'h50); d0(1, 301, 8'h51, 0); d1(1, 400, 8'h60, 1);
    tick(); wr("l_b", 301, 8'h51); chk("l_rdy1a", req1_ready, 0); d0(1, 302, 8'h52, 0);
    tick(); wr("l_c", 302, 8'h52); chk("l_rdy1b", req1_ready, 0); d0(1, 303, 8'h53, 1);
    tick(); wr("l_d", 303, 8'h53); chk("l_g1", grant, 2'b10); chk("l_rdy1c", req1_ready, 1);
    d0(0, 0, 0, 0);
    tick(); wr("l_e", 400, 8'h60); d1(0, 0, 0, 0);
    tick(); chk("l_en", fbuf_en_wr, 0); chk("l_gi", grant, 0);

    // out-of-range beat is dropped and counted, boundary address is written
    d0(1, 307200, 8'h55, 1);
    tick(); chk("o_g0", grant, 2'b01);
    tick(); chk("o_en", fbuf_en_wr, 0); chk("o_we", fbuf_wrea, 0);
    chk("o_cnt", oob_count, 1); chk("o_rel", grant, 0); chk("o_hold", fbuf_addr, 400);
    d0(1, 307199, 8'h66, 1);
    tick(); chk("o_g0b", grant, 2'b01); chk("o_en2", fbuf_en_wr, 0);
    tick(); wr("o_edge", 307199, 8'h66); chk("o_cnt2", oob_count, 1); d0(0, 0, 0, 0);

    // stall timeout: one beat, then 16 idle cycles with req1 waiting
    d0(1, 500, 8'h70, 0);
    tick(); chk("t_g0", grant, 2'b01);
    tick(); wr("t_a", 500, 8'h70); d0(0, 0, 0, 0); d1(1, 600, 8'h80, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("t_hold", grant, 2'b01); chk("t_cnt0", timeout_count, 0); chk("t_noleak", fbuf_en_wr, 0);
    tick(); chk("t_g1", grant, 2'b10); chk("t_cnt1", timeout_count, 1);
    tick(); wr("t_b", 600, 8'h80); d1(0, 0, 0, 0);
    tick();

    // reset mid-burst: pointer favours req1 beforehand, req0 must win after
    d0(1, 690, 8'h90, 1); d1(1, 700, 8'hA0, 0);
    tick(); chk("r_g0", grant, 2'b01);
    tick(); wr("r_a", 690, 8'h90); chk("r_g1", grant, 2'b10); d0(0, 0, 0, 0);
    tick(); wr("r_b", 700, 8'hA0); d1(1, 701, 8'hA1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("r_grant", grant, 0); chk("r_en", fbuf_en_wr, 0); chk("r_we", fbuf_wrea, 0);
    chk("r_rdy", {req1_ready, req0_ready}, 0);
    chk("r_oob", oob_count, 0); chk("r_tmo", timeout_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    d0(1, 800, 8'hB0, 1); d1(1, 801, 8'hB1, 1);
    tick(); chk("r_win0", grant, 2'b01); chk("r_nowr", fbuf_en_wr, 0);
    tick(); wr("r_c", 800, 8'hB0); chk("r_g1b", grant, 2'b10); d0(0, 0, 0, 0);
    tick(); wr("r_d", 801, 8'hB1); chk("r_gi", grant, 0); d1(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fbuf_write_arbiter.md
Name: fbuf_write_arbiter

Overview:
- Shares the single write-only framebuffer BRAM port between two requesters.
- Requester 0 is the GPU command handler's pixel/primitive writes; requester 1 is a fill/blit engine.
- Arbitration is round-robin with burst locking: a granted requester keeps the port until it presents a beat with last set.
- Output writes are registered, out-of-range addresses are suppressed and counted, and a stalled burst is force-released after a timeout.

Parameters:
FBUF_ADDR_WIDTH, 19, framebuffer address width
FBUF_DATA_WIDTH, 8, framebuffer pixel width
FBUF_DEPTH, 307200, valid addresses are 0..FBUF_DEPTH-1 (640x480)
LOCK_TIMEOUT, 16, consecutive idle cycles (valid low) of a granted requester before its grant is revoked; must be >= 2
CNT_WIDTH, 16, width of oob_count and timeout_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 beat valid
req0_ready  out  1  requester 0 beat accepted this cycle when valid and ready are both high
req0_addr  in  FBUF_ADDR_WIDTH  requester 0 pixel address
req0_data  in  FBUF_DATA_WIDTH  requester 0 pixel data
req0_last  in  1  final beat of requester 0 burst
req1_valid, req1_ready, req1_addr, req1_data, req1_last  as requester 0, for requester 1
fbuf_en_wr  out  1  BRAM enable
fbuf_wrea  out  1  BRAM write enable
fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address
fbuf_data  out  FBUF_DATA_WIDTH  BRAM write data
grant  out  2  one-hot current owner; 00 when idle
oob_count  out  CNT_WIDTH  saturating count of suppressed out-of-range beats
timeout_count  out  CNT_WIDTH  saturating count of forced grant releases

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; round-robin pointer is cleared so requester 0 has priority first.
  - All outputs, the idle counter and both count registers go to 0.
  - Any burst in flight is abandoned; the output stage issues no write after reset.
- States: IDLE, OWN0, OWN1.
  - grant = 00 in IDLE, 01 in OWN0, 10 in OWN1.
  - reqN_ready = (state == OWNN). It comes only from registered state, never combinationally from valid.
- IDLE transitions:
  - Only one valid high: go to that requester's OWN state.
  - Both valid high: go to the requester the pointer favours.
  - Grant decision takes one cycle, so the first beat is accepted no earlier than the cycle after valid rises.
- In OWNN, a beat is accepted when reqN_valid && reqN_ready.
  - Accepted beat with last = 0: stay in OWNN.
  - Accepted beat with last = 1:
    - Pointer moves to favour the other requester.
    - If the other requester's valid is high in that cycle, go directly to its OWN state (no bubble); otherwise go to IDLE.
- Lock timeout:
  - While in OWNN with reqN_valid low, the idle counter increments; any cycle with reqN_valid high clears it.
  - When the counter reaches LOCK_TIMEOUT:
    - Grant is released using the same next-state rule as a last beat.
    - timeout_count increments, saturating at all-ones.
    - The idle counter clears.
- Output stage (1-cycle latency):
  - Accepted beat in cycle T with addr < FBUF_DEPTH: in cycle T+1, fbuf_en_wr = 1, fbuf_wrea = 1, and fbuf_addr/fbuf_data carry the beat's address/data.
  - Accepted beat with addr >= FBUF_DEPTH: in cycle T+1, fbuf_en_wr = 0 and fbuf_wrea = 0. oob_count increments (saturating). The burst continues normally, and last is still honoured.
  - No accepted beat in cycle T: fbuf_en_wr and fbuf_wrea are 0 in T+1. fbuf_addr and fbuf_data hold their last value.
- Throughput: one beat per cycle while valid is held.
- The non-granted requester's inputs are ignored entirely, including its last.
- Simultaneous last beat and timeout expiry cannot occur, since valid is high on the last beat and that clears the idle counter.

Test Plan:
- Single request: req0 sends 3 beats at addrs 10, 11, 12 with data 0xA1, 0xA2, 0xA3, last on the 3rd, valid held throughout. Required response: grant = 01 one cycle after valid rises; fbuf_en_wr/fbuf_wrea pulse for 3 consecutive cycles with matching addr/data; grant returns to 00.
- Contention: req0 and req1 both assert from reset with 2-beat bursts. Required response: req0 is served first, then req1 with no idle cycle (grant 01 -> 10). A second round with both requesting again is served req0 first, because the pointer returned to req0 after req1's burst.
- Burst lock: req1 requests mid-way through a 4-beat req0 burst. Required response: req1_ready stays 0 until req0's last beat is accepted, and no req1 beat reaches fbuf_* early.
- Out-of-range: req0 sends a single last beat at addr 307200. Required response: no BRAM write, oob_count = 1, grant released. A following beat at addr 307199 is written.
- Stall timeout: req0 sends 1 non-last beat, then drops valid for 16 cycles while req1 is valid. Required response: grant moves to 10 after 16 idle cycles and timeout_count = 1.
- Reset mid-burst: assert rst_n low asynchronously during the 2nd beat of a req1 burst. Required response: grant, fbuf_en_wr, fbuf_wrea, both readies and both counts go to 0 immediately. After release, req0 wins first when both requesters are valid.
